ps2_movement_decoder: RTL and testbench
=======================================

Name: ps2_movement_decoder

Overview:
Upstream feeder of the player update stage. Receives PS/2 set-2 scancodes on kb_clock/kb_dat and decodes make/break sequences for the four arrow keys. Produces held-key levels turn_right, turn_left, move_forward, move_backward, which the player update stage samples on its start strobe. Contains a frame receiver with abort timeout and a prefix-tracking decoder FSM.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the kb_clock/kb_dat synchronisers (minimum 2).
TIMEOUT_CYCLES, 50000, system clocks without a kb_clock falling edge before a partial frame is aborted (1 ms at 50 MHz).

Ports:
clock  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
kb_clock  input  1  raw PS/2 clock, asynchronous.
kb_dat  input  1  raw PS/2 data, asynchronous.
turn_right  output  1  right arrow held.
turn_left  output  1  left arrow held.
move_forward  output  1  up arrow held.
move_backward  output  1  down arrow held.
byte_valid  output  1  one-cycle pulse when a good frame is received.
byte_data  output  8  last good byte; valid while byte_valid is high, held otherwise.
rx_error  output  1  one-cycle pulse on parity error, bad stop bit or timeout.

Behaviour:
- Reset: all outputs 0, byte_data 8'h00, receiver in RX_IDLE, prefix flags ext/brk cleared, timeout counter 0.
- Sync: both inputs pass through SYNC_STAGES flops. Falling edge = registered previous kb_clock 1 and current 0 (one-cycle strobe fe).
- Receiver FSM (one transition per fe, except timeout):
  RX_IDLE: on fe, data 0 -> RX_DATA with bit count 0; data 1 (bad start) -> stay, no error.
  RX_DATA: shift data in LSB-first; after 8th bit -> RX_PARITY.
  RX_PARITY: capture parity bit -> RX_STOP.
  RX_STOP: on fe, if stop 1 and XOR of the 8 data bits and parity is 1 (odd parity), byte_valid pulses the next cycle with byte_data; otherwise rx_error pulses. Then RX_IDLE.
  Timeout: in any non-idle state, counter increments each clock and clears on fe. At TIMEOUT_CYCLES-1 -> RX_IDLE with an rx_error pulse. Counter held at 0 in RX_IDLE.
- Decoder, acting on byte_valid only:
  8'hE0 sets ext. 8'hF0 sets brk. Any other byte: if ext, match 8'h75 up, 8'h72 down, 8'h6B left, 8'h74 right; the matched output := ~brk. Clear ext and brk after every non-prefix byte, matched or not.
  Without ext, all codes are ignored, e.g. keypad 8'h75, or BAT 8'hAA.
  rx_error clears ext and brk. Key levels are unchanged.
- Latency: fe sampling the stop bit at cycle N -> byte_valid at N+1 -> key output update at N+2.
- Multiple keys: outputs are independent and may be high together. Arbitration belongs to the consumer.
- Repeat make codes: idempotent. Break without a prior make: output stays 0.
- Reset mid-frame: frame discarded, no pulses, the next start bit is received cleanly.

Optional Feature:
WASD_EN
- Defined: non-extended make/break codes also drive the outputs: 8'h1D W forward, 8'h1B S backward, 8'h1C A left, 8'h23 D right. The output is the OR of the arrow-key and letter-key held state, tracked as separate internal bits, so releasing one key does not drop the other.
- Undefined: only E0-prefixed arrow codes are decoded, and non-extended bytes are ignored.

Decomposition:
- Package ps2_pkg holds:
  - scancode constants SC_EXT=8'hE0, SC_BREAK=8'hF0, SC_UP/SC_DOWN/SC_LEFT/SC_RIGHT and the WASD codes;
  - receiver state encoding RX_IDLE/RX_DATA/RX_PARITY/RX_STOP.
- One sub-module, ps2_rx_frame, owns the synchronisers, edge detect, receiver FSM, parity check and timeout. It outputs byte_valid/byte_data/rx_error.
- The decoder FSM stays in the top level.

Test Plan:
- Send frames E0, 75 with correct odd parity -> byte_valid pulses twice; move_forward rises exactly 2 clocks after the stop-bit fe of the 75 frame; other outputs stay 0.
- Send E0 75, E0 6B, E0 F0 75 -> after the sequence move_forward=0, turn_left=1.
- Send frame 8'h74 with parity bit flipped -> rx_error single pulse, no byte_valid, turn_right stays 0. Then E0 74 -> turn_right=1.
- Send start bit plus 4 data bits, then hold kb_clock high for TIMEOUT_CYCLES -> rx_error pulse, receiver returns to RX_IDLE. A following clean E0 72 sets move_backward=1.
- Send a bare 75 (no E0), then a bare F0 75 -> all outputs remain 0. With WASD_EN defined, 1D gives move_forward=1 and F0 1D returns it to 0.
- Assert reset for 1 cycle in mid-frame while turn_left=1 -> all outputs 0 on the next cycle, then a complete E0 6B frame pair sets turn_left=1 again.

Source files
------------

// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 movement decoder:
//   - PS/2 set-2 scancode constants (prefixes, arrow keys, WASD letters)
//   - receiver state encoding for ps2_rx_frame
//   - key index positions inside the 4-bit held-key vectors
//   - helpers: odd-parity check, scancode-to-key masks, held-state update
// ----------------------------------------------------------------------------
package ps2_pkg;

  // Prefix codes
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  // Extended (E0-prefixed) arrow keys
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Non-extended letter keys
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;

  // Bit positions in the held-key vectors
  localparam int KEY_FWD   = 0;
  localparam int KEY_BWD   = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd count of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  // One-hot key mask for an extended arrow code, zero when not an arrow
  function automatic logic [3:0] arrow_key_mask(input logic [7:0] code);
    logic [3:0] mask;
    case (code)
      SC_UP:    mask = 4'b0001;
      SC_DOWN:  mask = 4'b0010;
      SC_LEFT:  mask = 4'b0100;
      SC_RIGHT: mask = 4'b1000;
      default:  mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // One-hot key mask for a non-extended WASD code, zero otherwise
  function automatic logic [3:0] wasd_key_mask(input logic [7:0] code);
    logic [3:0] mask;
    case (code)
      SC_W:    mask = 4'b0001;
      SC_S:    mask = 4'b0010;
      SC_A:    mask = 4'b0100;
      SC_D:    mask = 4'b1000;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Make sets the masked bits, break clears them; a zero mask leaves state alone
  function automatic logic [3:0] apply_key(input logic [3:0] held,
                                           input logic [3:0] mask,
                                           input logic       brk);
    logic [3:0] res;
    if (brk) begin
      res = held & ~mask;
    end else begin
      res = held | mask;
    end
    return res;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// ----------------------------------------------------------------------------
// ps2_rx_frame
// PS/2 frame receiver: synchronises the raw PS/2 clock/data, detects falling
// edges of the PS/2 clock, shifts in start/8 data/parity/stop bits, checks
// odd parity and the stop bit, and aborts a partial frame after a stall.
//
// Parameters:
//   SYNC_STAGES    synchroniser depth (values below 2 are treated as 2)
//   TIMEOUT_CYCLES clocks without a PS/2 falling edge before a frame aborts
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   kb_clock    in   raw PS/2 clock (asynchronous)
//   kb_dat      in   raw PS/2 data (asynchronous)
//   byte_valid  out  one-cycle pulse for a good frame
//   byte_data   out  last good byte, held between frames
//   rx_error    out  one-cycle pulse on parity/stop error or timeout
// ----------------------------------------------------------------------------
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       kb_clock,
  input  logic       kb_dat,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       rx_error
);

  localparam int SS    = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [SS-1:0]    r_clk_sync;
  logic [SS-1:0]    r_dat_sync;
  logic             r_clk_prev;
  rx_state_e        r_state;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_par;
  logic [CNT_W-1:0] r_to_cnt;
  logic             r_byte_valid;
  logic [7:0]       r_byte_data;
  logic             r_rx_error;

  logic w_clk;
  logic w_dat;
  logic w_fe;

  assign w_clk = r_clk_sync[SS-1];
  assign w_dat = r_dat_sync[SS-1];
  // The clock chain resets low so a line that is already high after reset
  // can never produce a spurious falling edge.
  assign w_fe  = r_clk_prev & ~w_clk;

  // Input synchronisers and previous-clock register for edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      r_clk_sync <= {SS{1'b0}};
      r_dat_sync <= {SS{1'b1}};
      r_clk_prev <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[SS-2:0], kb_clock};
      r_dat_sync <= {r_dat_sync[SS-2:0], kb_dat};
      r_clk_prev <= w_clk;
    end
  end

  // Receiver FSM with stall timeout and registered result pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= RX_IDLE;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'h00;
      r_par        <= 1'b0;
      r_to_cnt     <= {CNT_W{1'b0}};
      r_byte_valid <= 1'b0;
      r_byte_data  <= 8'h00;
      r_rx_error   <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_rx_error   <= 1'b0;
      if (r_state == RX_IDLE) begin
        r_to_cnt <= {CNT_W{1'b0}};
        // A high data bit on the first edge is not a start bit; ignore it
        if (w_fe && !w_dat) begin
          r_state   <= RX_DATA;
          r_bit_cnt <= 3'd0;
        end else begin
          r_state <= RX_IDLE;
        end
      end else if (w_fe) begin
        r_to_cnt <= {CNT_W{1'b0}};
        case (r_state)
          RX_DATA: begin
            r_shift   <= {w_dat, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= RX_PARITY;
            end else begin
              r_state <= RX_DATA;
            end
          end
          RX_PARITY: begin
            r_par   <= w_dat;
            r_state <= RX_STOP;
          end
          RX_STOP: begin
            if (w_dat && odd_parity_ok(r_shift, r_par)) begin
              r_byte_valid <= 1'b1;
              r_byte_data  <= r_shift;
            end else begin
              r_rx_error <= 1'b1;
            end
            r_state <= RX_IDLE;
          end
          default: begin
            r_state <= RX_IDLE;
          end
        endcase
      end else if (r_to_cnt == TO_LAST) begin
        r_state    <= RX_IDLE;
        r_to_cnt   <= {CNT_W{1'b0}};
        r_rx_error <= 1'b1;
      end else begin
        r_to_cnt <= r_to_cnt + CNT_W'(1);
      end
    end
  end

  assign byte_valid = r_byte_valid;
  assign byte_data  = r_byte_data;
  assign rx_error   = r_rx_error;

endmodule

// File: rtl/ps2_movement_decoder.sv
// ----------------------------------------------------------------------------
// ps2_movement_decoder
// Turns PS/2 set-2 make/break sequences for the arrow keys into held-key
// levels for the player update stage. Frame reception lives in ps2_rx_frame;
// this level tracks the E0 / F0 prefixes and the held state of each key.
//
// Build option: define WASD_EN to also decode non-extended W/S/A/D codes.
// Letter and arrow held states are kept separately and ORed at the outputs,
// so releasing one key does not drop the other.
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   synchronous active-high reset
//   kb_clock       in   raw PS/2 clock (asynchronous)
//   kb_dat         in   raw PS/2 data (asynchronous)
//   turn_right     out  right held
//   turn_left      out  left held
//   move_forward   out  up/forward held
//   move_backward  out  down/backward held
//   byte_valid     out  one-cycle pulse per good frame
//   byte_data      out  last good byte
//   rx_error       out  one-cycle pulse on a bad or aborted frame
// ----------------------------------------------------------------------------
module ps2_movement_decoder
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       kb_clock,
  input  logic       kb_dat,
  output logic       turn_right,
  output logic       turn_left,
  output logic       move_forward,
  output logic       move_backward,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       rx_error
);

  logic       w_byte_valid;
  logic [7:0] w_byte_data;
  logic       w_rx_error;

  logic       r_ext;
  logic       r_brk;
  logic [3:0] r_arrow;
  logic       w_ext_nxt;
  logic       w_brk_nxt;
  logic [3:0] w_arrow_nxt;
  logic [3:0] w_keys;
`ifdef WASD_EN
  logic [3:0] r_wasd;
  logic [3:0] w_wasd_nxt;
  logic [3:0] r_keys;
`endif

  ps2_rx_frame #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clock      (clock),
    .reset      (reset),
    .kb_clock   (kb_clock),
    .kb_dat     (kb_dat),
    .byte_valid (w_byte_valid),
    .byte_data  (w_byte_data),
    .rx_error   (w_rx_error)
  );

  // Next-state of the prefix flags and held-key vectors
  always_comb begin
    w_ext_nxt   = r_ext;
    w_brk_nxt   = r_brk;
    w_arrow_nxt = r_arrow;
`ifdef WASD_EN
    w_wasd_nxt  = r_wasd;
`endif
    if (w_rx_error) begin
      // A corrupted frame may have been part of a prefixed sequence
      w_ext_nxt = 1'b0;
      w_brk_nxt = 1'b0;
    end else if (w_byte_valid) begin
      if (w_byte_data == SC_EXT) begin
        w_ext_nxt = 1'b1;
      end else if (w_byte_data == SC_BREAK) begin
        w_brk_nxt = 1'b1;
      end else begin
        if (r_ext) begin
          w_arrow_nxt = apply_key(r_arrow, arrow_key_mask(w_byte_data), r_brk);
        end else begin
`ifdef WASD_EN
          w_wasd_nxt = apply_key(r_wasd, wasd_key_mask(w_byte_data), r_brk);
`else
          w_arrow_nxt = r_arrow;
`endif
        end
        // Any non-prefix byte ends the sequence, recognised or not
        w_ext_nxt = 1'b0;
        w_brk_nxt = 1'b0;
      end
    end else begin
      w_ext_nxt = r_ext;
      w_brk_nxt = r_brk;
    end
  end

  // Decoder state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ext   <= 1'b0;
      r_brk   <= 1'b0;
      r_arrow <= 4'b0000;
`ifdef WASD_EN
      r_wasd  <= 4'b0000;
      r_keys  <= 4'b0000;
`endif
    end else begin
      r_ext   <= w_ext_nxt;
      r_brk   <= w_brk_nxt;
      r_arrow <= w_arrow_nxt;
`ifdef WASD_EN
      r_wasd  <= w_wasd_nxt;
      r_keys  <= w_arrow_nxt | w_wasd_nxt;
`endif
    end
  end

`ifdef WASD_EN
  assign w_keys = r_keys;
`else
  assign w_keys = r_arrow;
`endif

  assign move_forward  = w_keys[KEY_FWD];
  assign move_backward = w_keys[KEY_BWD];
  assign turn_left     = w_keys[KEY_LEFT];
  assign turn_right    = w_keys[KEY_RIGHT];
  assign byte_valid    = w_byte_valid;
  assign byte_data     = w_byte_data;
  assign rx_error      = w_rx_error;

endmodule

// File: tb/tb_ps2_movement_decoder.sv
// ----------------------------------------------------------------------------
// tb_ps2_movement_decoder
// Directed bench: drives PS/2 frames bit by bit and checks byte pulses,
// error pulses and key levels against hand-computed values.
// Key vector order in checks: {turn_right, turn_left, move_backward, move_forward}
// ----------------------------------------------------------------------------
module tb_ps2_movement_decoder;

  localparam int TO   = 200;
  localparam int HALF = 5;

  logic       clock = 1'b0;
  logic       reset;
  logic       kb_clock;
  logic       kb_dat;
  logic       turn_right, turn_left, move_forward, move_backward;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       rx_error;

  int errors = 0;
  int checks = 0;
  int bv_cnt, bv_cyc, err_cnt, err_cyc;
  logic [7:0] last_byte;
  logic mf_hist [1:8];

  ps2_movement_decoder #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .kb_clock      (kb_clock),
    .kb_dat        (kb_dat),
    .turn_right    (turn_right),
    .turn_left     (turn_left),
    .move_forward  (move_forward),
    .move_backward (move_backward),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .rx_error      (rx_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] keys();
    return {turn_right, turn_left, move_backward, move_forward};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    kb_dat = b;
    wait_cyc(HALF);
    kb_clock = 1'b0;
    wait_cyc(HALF);
    kb_clock = 1'b1;
  endtask

  // Full frame; the stop-bit edge is followed by a cycle-by-cycle monitor
  task automatic send_frame(input logic [7:0] d, input logic flip_par);
    logic par;
    par = (~^d) ^ flip_par;
    bv_cnt = 0; bv_cyc = 0; err_cnt = 0;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    kb_dat = 1'b1;
    wait_cyc(HALF);
    kb_clock = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clock);
      #1;
      mf_hist[k] = move_forward;
      if (byte_valid) begin
        bv_cnt++;
        if (bv_cyc == 0) bv_cyc = k;
        last_byte = byte_data;
      end
      if (rx_error) err_cnt++;
    end
    kb_clock = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  // Start bit plus n data bits, then the line is left idle-high
  task automatic send_partial(input int n, input logic [7:0] d);
    send_bit(1'b0);
    for (int i = 0; i < n; i++) send_bit(d[i]);
    kb_dat = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; kb_clock = 1'b1; kb_dat = 1'b1; last_byte = 8'h00;
    wait_cyc(3);
    check("rst_keys", {28'd0, keys()}, 32'h0);
    check("rst_bv", {31'd0, byte_valid}, 32'h0);
    check("rst_data", {24'd0, byte_data}, 32'h0);
    check("rst_err", {31'd0, rx_error}, 32'h0);
    reset = 1'b0;
    wait_cyc(5);

    // Unprefixed codes are ignored
    send_frame(8'h75, 1'b0);
    check("bare75_bv", bv_cnt, 32'd1);
    check("bare75_data", {24'd0, last_byte}, 32'h75);
    check("bare75_keys", {28'd0, keys()}, 32'h0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("bareF075_keys", {28'd0, keys()}, 32'h0);
    send_frame(8'h1D, 1'b0);
`ifdef WASD_EN
    check("w_make", {28'd0, keys()}, 32'h1);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1D, 1'b0);
    check("w_break", {28'd0, keys()}, 32'h0);
`else
    check("w_ignored", {28'd0, keys()}, 32'h0);
`endif

    // E0 75: forward, with latency check on the 75 frame
    send_frame(8'hE0, 1'b0);
    check("e0_bv", bv_cnt, 32'd1);
    check("e0_data", {24'd0, last_byte}, 32'hE0);
    send_frame(8'h75, 1'b0);
    check("up_bv_cnt", bv_cnt, 32'd1);
    check("up_bv_cyc", bv_cyc, 32'd3);
    check("up_mf_before", {31'd0, mf_hist[3]}, 32'h0);
    check("up_mf_after", {31'd0, mf_hist[4]}, 32'h1);
    check("up_keys", {28'd0, keys()}, 32'h1);

    // Left make, then up break
    send_frame(8'hE0, 1'b0);
    send_frame(8'h6B, 1'b0);
    check("left_keys", {28'd0, keys()}, 32'h5);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("upbrk_keys", {28'd0, keys()}, 32'h4);

    // Parity error on 74, then a clean E0 74
    send_frame(8'h74, 1'b1);
    check("par_err", err_cnt, 32'd1);
    check("par_bv", bv_cnt, 32'd0);
    check("par_data_held", {24'd0, byte_data}, 32'h75);
    check("par_keys", {28'd0, keys()}, 32'h4);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h74, 1'b0);
    check("right_keys", {28'd0, keys()}, 32'hC);

    // Partial frame abandoned: timeout abort
    send_partial(4, 8'h0A);
    err_cnt = 0; err_cyc = 0; bv_cnt = 0;
    for (int k = 1; k <= TO + 100; k++) begin
      @(posedge clock);
      #1;
      if (rx_error) begin
        err_cnt++;
        if (err_cyc == 0) err_cyc = k;
      end
      if (byte_valid) bv_cnt++;
    end
    check("to_err", err_cnt, 32'd1);
    check("to_bv", bv_cnt, 32'd0);
    check("to_window", {31'd0, (err_cyc >= TO - HALF - 10) && (err_cyc <= TO + 5)}, 32'h1);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h72, 1'b0);
    check("down_keys", {28'd0, keys()}, 32'hE);

    // Reset in the middle of a frame while left is held
    check("pre_rst_left", {31'd0, turn_left}, 32'h1);
    send_partial(3, 8'h05);
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    check("midrst_keys", {28'd0, keys()}, 32'h0);
    check("midrst_data", {24'd0, byte_data}, 32'h0);
    bv_cnt = 0; err_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clock);
      #1;
      if (byte_valid) bv_cnt++;
      if (rx_error) err_cnt++;
    end
    check("midrst_quiet", bv_cnt + err_cnt, 32'd0);
    send_frame(8'hE0, 1'b0);
    check("post_e0_bv", bv_cnt, 32'd1);
    send_frame(8'h6B, 1'b0);
    check("post_left_keys", {28'd0, keys()}, 32'h4);
    check("post_left_data", {24'd0, byte_data}, 32'h6B);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
